mult_hilo_ctrl: RTL and testbench
=================================

Name: mult_hilo_ctrl

Overview:
- Sequencer and HI/LO result register that sits directly upstream of the 32-bit shift-add unsigned multiplier.
- Accepts a MULTU request, drives the multiplier's 6-bit `Signal` code for 33 cycles (FIRST, 31x MULTU, OUT) and holds the operands stable during that time.
- Captures the 64-bit product into HI/LO registers and serves MFHI/MFLO reads and MTHI/MTLO writes to the ALU datapath.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH; step count equals WIDTH.
- CODE_FIRST, 6'b111110, multiplier code that loads dataB and performs step 1.
- CODE_MULTU, 6'b011001, multiplier code for one add/shift step.
- CODE_OUT, 6'b111111, multiplier code for hold/idle.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge).
- start  in  1  one-cycle MULTU request; sampled only in IDLE.
- opA  in  WIDTH  multiplicand.
- opB  in  WIDTH  multiplier operand.
- mul_signal  out  6  code driven to multiplier `Signal`.
- mul_dataA  out  WIDTH  latched opA, to multiplier `dataA`.
- mul_dataB  out  WIDTH  latched opB, to multiplier `dataB`.
- mul_product  in  2*WIDTH  multiplier `dataOut`.
- busy  out  1  high from the cycle after start is accepted until capture.
- done  out  1  one-cycle pulse after HI/LO are updated.
- wr_en  in  1  MTHI/MTLO write strobe.
- wr_sel  in  1  0 selects LO, 1 selects HI (for both write and read).
- wr_data  in  WIDTH  write data.
- rd_data  out  WIDTH  combinational read: HI if wr_sel==1, else LO.

Behaviour:
- States: IDLE, RUN, CAPTURE. All state changes on the rising clk edge.
- Reset (reset==0): state=IDLE; cnt=0; hi=0; lo=0; mul_dataA=0; mul_dataB=0; busy=0; done=0; mul_signal=CODE_OUT. Reset overrides everything, including mid-operation; an aborted multiply leaves HI/LO at 0.
- mul_signal by state:
  - IDLE: CODE_OUT.
  - RUN, cnt==0: CODE_FIRST.
  - RUN, cnt 1..WIDTH-1: CODE_MULTU.
  - CAPTURE: CODE_OUT.
- IDLE with start==1 at edge E0:
  - Latch opA into mul_dataA and opB into mul_dataB.
  - cnt=0; state goes to RUN; busy=1.
- RUN: each edge increments cnt. On the edge where cnt==WIDTH-1, go to CAPTURE.
  - Multiplier steps occur on edges E1..E32 (WIDTH=32).
- CAPTURE at edge E33:
  - hi=mul_product[2W-1:W]; lo=mul_product[W-1:0].
  - busy=0; done=1 for exactly one cycle; state goes to IDLE.
- Total latency is 33 edges from the start edge to the HI/LO update.
- mul_dataA and mul_dataB hold their values until the next accepted start.
- start while busy: ignored, with no queueing.
- start on the same edge done is high: accepted, because the state is already IDLE.
- wr_en:
  - Honoured only when busy==0 and state!=CAPTURE. Updates HI or LO per wr_sel on the edge.
  - Ignored while busy or in CAPTURE; the capture result wins.
- rd_data is valid in any state. During busy it returns the previous HI/LO.
- Arithmetic is unsigned only. No overflow flag; the full 64-bit product is retained.
- cnt is $clog2(WIDTH) bits and returns to 0 on leaving RUN.

Test Plan:
- Reset held low for 2 cycles with start=1 -> busy=0, done=0, mul_signal=6'h3F, rd_data=0 for both wr_sel values.
- start with opA=3, opB=5 at E0 -> mul_signal=FIRST in cycle 1, MULTU in cycles 2-32, OUT in cycle 33; done pulses after E33; LO=15, HI=0.
- opA=opB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; opA=0x80000000, opB=2 -> HI=1, LO=0.
- Second start at cycle 10 with different operands -> ignored; the result matches the first operands; mul_dataB is unchanged throughout.
- wr_en=1, wr_sel=1, wr_data=0xDEADBEEF while idle -> rd_data(sel=1)=0xDEADBEEF. The same write issued while busy -> HI still equals the product after done.
- reset driven low at cycle 15 of RUN -> state IDLE, HI=LO=0, mul_signal=OUT. A new start afterwards yields the correct product (bench also resets the multiplier).

Source files
------------

// File: rtl/mult_hilo_if.sv
// Bus between the MULTU sequencer / HI-LO registers and the ALU datapath plus
// the downstream shift-add multiplier.
interface mult_hilo_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   opA;
  logic [WIDTH-1:0]   opB;
  logic [5:0]         mul_signal;
  logic [WIDTH-1:0]   mul_dataA;
  logic [WIDTH-1:0]   mul_dataB;
  logic [2*WIDTH-1:0] mul_product;
  logic               busy;
  logic               done;
  logic               wr_en;
  logic               wr_sel;
  logic [WIDTH-1:0]   wr_data;
  logic [WIDTH-1:0]   rd_data;

  modport master (
    output start, opA, opB, mul_product, wr_en, wr_sel, wr_data,
    input  mul_signal, mul_dataA, mul_dataB, busy, done, rd_data
  );

  modport slave (
    input  start, opA, opB, mul_product, wr_en, wr_sel, wr_data,
    output mul_signal, mul_dataA, mul_dataB, busy, done, rd_data
  );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// MULTU sequencer for the shift-add multiplier with HI/LO result registers
// and MFHI/MFLO/MTHI/MTLO access.
module mult_hilo_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [5:0]  CODE_FIRST = 6'b111110,
  parameter logic [5:0]  CODE_MULTU = 6'b011001,
  parameter logic [5:0]  CODE_OUT   = 6'b111111
) (
  input  logic        clk,
  input  logic        reset,
  mult_hilo_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   hi_q,     hi_d;
  logic [WIDTH-1:0]   lo_q,     lo_d;
  logic [WIDTH-1:0]   data_a_q, data_a_d;
  logic [WIDTH-1:0]   data_b_q, data_b_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [5:0]         signal_q, signal_d;

  // Next-state, datapath and multiplier code decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    signal_d = CODE_OUT;

    // MTHI/MTLO only while no multiply owns HI/LO
    if (bus.wr_en && !busy_q && (state_q != S_CAPTURE)) begin
      if (bus.wr_sel) hi_d = bus.wr_data;
      else            lo_d = bus.wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          data_a_d = bus.opA;
          data_b_d = bus.opB;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        hi_d    = bus.mul_product[2*WIDTH-1:WIDTH];
        lo_d    = bus.mul_product[WIDTH-1:0];
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    // Code is registered from the next state so it lines up with the state it names
    case (state_d)
      S_RUN:   signal_d = (cnt_d == '0) ? CODE_FIRST : CODE_MULTU;
      default: signal_d = CODE_OUT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      signal_q <= CODE_OUT;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      signal_q <= signal_d;
    end
  end

  assign bus.mul_signal = signal_q;
  assign bus.mul_dataA  = data_a_q;
  assign bus.mul_dataB  = data_b_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rd_data    = bus.wr_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed plus randomized bench for mult_hilo_ctrl, with a behavioural
// shift-add multiplier and HI/LO reference values computed by plain arithmetic.
module tb_mult_hilo_ctrl;

  localparam logic [5:0] C_FIRST = 6'b111110;
  localparam logic [5:0] C_MULTU = 6'b011001;
  localparam logic [5:0] C_OUT   = 6'b111111;

  logic clk;
  logic reset;
  logic [64:0] mp;
  logic [31:0] exp_hi, exp_lo;
  int n_pass, n_fail, n_total;

  mult_hilo_if #(.WIDTH(32)) bus ();

  mult_hilo_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: FIRST loads B and steps, MULTU steps, anything else holds
  function automatic logic [64:0] mstep(input logic [64:0] p, input logic [31:0] a);
    logic [64:0] t;
    t = p;
    if (p[0]) t[64:32] = {1'b0, p[63:32]} + {1'b0, a};
    return t >> 1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) mp <= '0;
    else if (bus.mul_signal == C_FIRST) mp <= mstep({33'd0, bus.mul_dataB}, bus.mul_dataA);
    else if (bus.mul_signal == C_MULTU) mp <= mstep(mp, bus.mul_dataA);
  end

  assign bus.mul_product = mp[63:0];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rd_both(input string tag);
    bus.wr_sel = 1'b1;
    #1 check({tag, "_hi"}, 64'(bus.rd_data), 64'(exp_hi));
    bus.wr_sel = 1'b0;
    #1 check({tag, "_lo"}, 64'(bus.rd_data), 64'(exp_lo));
  endtask

  task automatic idle_tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    tick();
    check("idle_done", 64'(bus.done), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_sig",  64'(bus.mul_signal), 64'(C_OUT));
  endtask

  task automatic idle_write(input logic sel, input logic [31:0] d);
    bus.start   = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    if (sel) exp_hi = d;
    else     exp_lo = d;
    #1 check("wr_rd",   64'(bus.rd_data), 64'(d));
    check("wr_done", 64'(bus.done), 64'd0);
    check_rd_both("wr_both");
  endtask

  // Starts a multiply in the current (idle) cycle; optional intruding start,
  // write during busy, or reset abort at the given run cycle (0 = none).
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input int intr_c,
                          input int wr_c, input logic wsel, input logic [31:0] wdat,
                          input int abort_c);
    logic [63:0] prod;
    logic [5:0]  esig;
    prod = 64'(a) * 64'(b);
    bus.start = 1'b1;
    bus.opA   = a;
    bus.opB   = b;
    bus.wr_en = 1'b0;
    tick();
    for (int c = 1; c <= 33; c++) begin
      bus.start  = 1'b0;
      bus.wr_en  = 1'b0;
      bus.wr_sel = c[0];
      if (c == abort_c) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        #1 check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_sig",  64'(bus.mul_signal), 64'(C_OUT));
        check("abort_da",   64'(bus.mul_dataA), 64'd0);
        check_rd_both("abort_rd");
        return;
      end
      if (c == intr_c) begin
        bus.start = 1'b1;
        bus.opA   = ~a;
        bus.opB   = ~b;
      end
      if (c == wr_c) begin
        bus.wr_en   = 1'b1;
        bus.wr_sel  = wsel;
        bus.wr_data = wdat;
      end
      #1;
      esig = (c == 1) ? C_FIRST : ((c == 33) ? C_OUT : C_MULTU);
      check("run_sig",  64'(bus.mul_signal), 64'(esig));
      check("run_busy", 64'(bus.busy), 64'd1);
      check("run_done", 64'(bus.done), 64'd0);
      check("run_da",   64'(bus.mul_dataA), 64'(a));
      check("run_db",   64'(bus.mul_dataB), 64'(b));
      check("run_rd",   64'(bus.rd_data), 64'(bus.wr_sel ? exp_hi : exp_lo));
      tick();
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    exp_hi = prod[63:32];
    exp_lo = prod[31:0];
    check("cap_done", 64'(bus.done), 64'd1);
    check("cap_busy", 64'(bus.busy), 64'd0);
    check("cap_sig",  64'(bus.mul_signal), 64'(C_OUT));
    check_rd_both("cap_rd");
  endtask

  initial begin
    logic [31:0] a, b, wd;
    int          ic, wc;
    logic        ws;
    n_pass = 0; n_fail = 0; n_total = 0;
    exp_hi = '0; exp_lo = '0;
    reset = 1'b0;
    bus.start = 1'b1;
    bus.opA = 32'h1234_5678;
    bus.opB = 32'h9ABC_DEF0;
    bus.wr_en = 1'b0;
    bus.wr_sel = 1'b0;
    bus.wr_data = '0;
    tick();
    tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_sig",  64'(bus.mul_signal), 64'(C_OUT));
    check("rst_da",   64'(bus.mul_dataA), 64'd0);
    check("rst_db",   64'(bus.mul_dataB), 64'd0);
    check_rd_both("rst_rd");
    reset = 1'b1;
    bus.start = 1'b0;
    idle_tick();

    run_mult(32'd3, 32'd5, 0, 0, 1'b0, 32'd0, 0);
    idle_tick();
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, 32'd0, 0);
    idle_tick();
    run_mult(32'h8000_0000, 32'd2, 0, 0, 1'b0, 32'd0, 0);
    idle_tick();
    run_mult(32'd1234, 32'd777, 10, 0, 1'b0, 32'd0, 0);
    idle_tick();

    idle_write(1'b1, 32'hDEAD_BEEF);
    idle_write(1'b0, 32'h0BAD_F00D);
    run_mult(32'h0001_0001, 32'hCAFE_0003, 0, 12, 1'b1, 32'hDEAD_BEEF, 0);
    idle_tick();
    run_mult(32'h7777_1111, 32'h0000_0F0F, 0, 33, 1'b0, 32'h5555_AAAA, 0);
    idle_tick();

    run_mult(32'hABCD_0123, 32'h4567_89AB, 0, 0, 1'b0, 32'd0, 15);
    idle_tick();
    run_mult(32'd100000, 32'd300000, 0, 0, 1'b0, 32'd0, 0);
    // start in the done cycle is accepted
    run_mult(32'h0F0F_0F0F, 32'hF0F0_F0F0, 0, 0, 1'b0, 32'd0, 0);
    idle_write(1'b0, 32'h1357_9BDF);

    for (int i = 0; i < 12; i++) begin
      a  = $urandom;
      b  = $urandom;
      ic = $urandom_range(0, 33);
      wc = $urandom_range(0, 33);
      ws = 1'($urandom_range(0, 1));
      wd = $urandom;
      run_mult(a, b, ic, wc, ws, wd, 0);
      case ($urandom_range(0, 2))
        0:       idle_tick();
        1:       idle_write(1'($urandom_range(0, 1)), $urandom);
        default: ;
      endcase
    end
    idle_tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
